// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scanner.
// Segment vectors are active-low, a = bit 6 through g = bit 0.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int scanIndexWidth(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h01;
      4'h1: seg = 7'h4F;
      4'h2: seg = 7'h12;
      4'h3: seg = 7'h06;
      4'h4: seg = 7'h4C;
      4'h5: seg = 7'h24;
      4'h6: seg = 7'h20;
      4'h7: seg = 7'h0F;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h04;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h60;
      4'hC: seg = 7'h31;
      4'hD: seg = 7'h42;
      4'hE: seg = 7'h30;
      4'hF: seg = 7'h38;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational nibble to active-low segment decoder.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/seven_seg_scanner.sv
// Double-buffered, PWM-dimmed scanner for common-anode seven-segment displays.
// Outputs are registered from next-state values, so they line up with scan_index.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int PRESCALE_W = 17,
  parameter int BRIGHT_W   = 3,
  localparam int IDX_W     = scanIndexWidth(DIGITS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     enable_in,
  input  logic [BRIGHT_W-1:0]   brightness_in,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            cathode,
  output logic                  dp_n,
  output logic [IDX_W-1:0]      scan_index,
  output logic                  frame_done
);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);

  logic [PRESCALE_W-1:0]  r_slot;
  logic [IDX_W-1:0]       r_index;
  logic [DIGITS-1:0][3:0] r_shDigits;
  logic [DIGITS-1:0]      r_shDp;
  logic [DIGITS-1:0]      r_shEn;
  logic [BRIGHT_W-1:0]    r_shBright;
  logic [DIGITS-1:0][3:0] r_acDigits;
  logic [DIGITS-1:0]      r_acDp;
  logic [DIGITS-1:0]      r_acEn;
  logic [BRIGHT_W-1:0]    r_acBright;

  logic                   w_slotWrap;
  logic                   w_boundary;
  logic                   w_on;
  logic [PRESCALE_W-1:0]  w_slotNext;
  logic [IDX_W-1:0]       w_indexNext;
  logic [DIGITS-1:0][3:0] w_acDigitsNext;
  logic [DIGITS-1:0]      w_acDpNext;
  logic [DIGITS-1:0]      w_acEnNext;
  logic [BRIGHT_W-1:0]    w_acBrightNext;
  logic [6:0]             w_seg;

  assign w_slotWrap = &r_slot;
  assign w_boundary = w_slotWrap && (r_index == LAST_IDX);
  assign w_slotNext = r_slot + PRESCALE_W'(1);

  always_comb begin
    w_indexNext = r_index;
    if (w_slotWrap) begin
      w_indexNext = (r_index == LAST_IDX) ? '0 : r_index + IDX_W'(1);
    end
  end

  // A load on the boundary cycle bypasses the shadow and lands in the frame that starts next.
  always_comb begin
    w_acDigitsNext = r_acDigits;
    w_acDpNext     = r_acDp;
    w_acEnNext     = r_acEn;
    w_acBrightNext = r_acBright;
    if (w_boundary) begin
      if (load) begin
        w_acDigitsNext = digits_in;
        w_acDpNext     = dp_in;
        w_acEnNext     = enable_in;
        w_acBrightNext = brightness_in;
      end else begin
        w_acDigitsNext = r_shDigits;
        w_acDpNext     = r_shDp;
        w_acEnNext     = r_shEn;
        w_acBrightNext = r_shBright;
      end
    end
  end

  assign w_on = (w_slotNext[PRESCALE_W-1 -: BRIGHT_W] < w_acBrightNext) && w_acEnNext[w_indexNext];

  seven_seg_decoder u_decoder (
    .i_nibble (w_acDigitsNext[w_indexNext]),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_slot     <= '0;
      r_index    <= '0;
      r_shDigits <= '0;
      r_shDp     <= '0;
      r_shEn     <= '0;
      r_shBright <= '0;
      r_acDigits <= '0;
      r_acDp     <= '0;
      r_acEn     <= '0;
      r_acBright <= '0;
    end else begin
      r_slot     <= w_slotNext;
      r_index    <= w_indexNext;
      r_acDigits <= w_acDigitsNext;
      r_acDp     <= w_acDpNext;
      r_acEn     <= w_acEnNext;
      r_acBright <= w_acBrightNext;
      if (load) begin
        r_shDigits <= digits_in;
        r_shDp     <= dp_in;
        r_shEn     <= enable_in;
        r_shBright <= brightness_in;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode      <= '1;
      cathode    <= SEG_BLANK;
      dp_n       <= 1'b1;
      scan_index <= '0;
      frame_done <= 1'b0;
    end else begin
      anode      <= w_on ? ~(ONE_HOT0 << w_indexNext) : '1;
      cathode    <= w_on ? w_seg : SEG_BLANK;
      dp_n       <= w_on ? ~w_acDpNext[w_indexNext] : 1'b1;
      scan_index <= w_indexNext;
      frame_done <= w_boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (DIGITS=4, PRESCALE_W=4, BRIGHT_W=2).
// Stimulus queues the expected appearance of each frame; the monitor checks it on frame_done.
module tb_seven_seg_scanner;

  typedef struct packed {
    logic [7:0]      id;
    logic [3:0][4:0] onClk;
    logic [3:0][6:0] cath;
    logic [3:0]      dpMask;
  } frameExp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  enable_in = '0;
  logic [1:0]  brightness_in = '0;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp_n;
  logic [1:0]  scan_index;
  logic        frame_done;

  int testsRun = 0;
  int testsFailed = 0;
  bit monitorBusy = 1'b0;
  frameExp_t expQ[$];

  seven_seg_scanner #(.DIGITS(4), .PRESCALE_W(4), .BRIGHT_W(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .load          (load),
    .digits_in     (digits_in),
    .dp_in         (dp_in),
    .enable_in     (enable_in),
    .brightness_in (brightness_in),
    .anode         (anode),
    .cathode       (cathode),
    .dp_n          (dp_n),
    .scan_index    (scan_index),
    .frame_done    (frame_done)
  );

  always #5 clock = ~clock;

  function automatic frameExp_t mkExp(input logic [7:0] id, input logic [19:0] onClk,
                                      input logic [27:0] cath, input logic [3:0] dpMask);
    frameExp_t e;
    e.id = id;
    e.onClk = onClk;
    e.cath = cath;
    e.dpMask = dpMask;
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] digits, input logic [3:0] dp,
                               input logic [3:0] en, input logic [1:0] bright);
    digits_in = digits;
    dp_in = dp;
    enable_in = en;
    brightness_in = bright;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic waitFrame(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: frame_done never seen within 200 cycles, expected a pulse", tag);
    end
  endtask

  // Called on the frame_done cycle (slot 0 of digit 0); consumes the frame plus the next pulse.
  task automatic checkOutput(input frameExp_t rec);
    int errs[4][4];
    logic [6:0] badGot[4][4];
    logic [6:0] badWant[4][4];
    logic [6:0] got[4];
    logic [6:0] want[4];
    int fdErr;
    int k;
    int s;
    bit on;
    string catName[4];
    catName[0] = "anode";
    catName[1] = "cathode";
    catName[2] = "dp_n";
    catName[3] = "scan_index";
    fdErr = 0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        errs[a][b] = 0;
        badGot[a][b] = '0;
        badWant[a][b] = '0;
      end
    for (int i = 0; i <= 64; i++) begin
      if (i > 0) @(negedge clock);
      if (i == 64) begin
        if (frame_done !== 1'b1) fdErr++;
        break;
      end
      if (i > 0 && frame_done !== 1'b0) fdErr++;
      k = i / 16;
      s = i % 16;
      on = (s < int'(rec.onClk[k]));
      got[0]  = {3'b0, anode};
      want[0] = on ? {3'b0, ~(4'b0001 << k)} : 7'h0F;
      got[1]  = cathode;
      want[1] = on ? rec.cath[k] : 7'h7F;
      got[2]  = {6'b0, dp_n};
      want[2] = on ? {6'b0, ~rec.dpMask[k]} : 7'h01;
      got[3]  = {5'b0, scan_index};
      want[3] = 7'(k);
      for (int c = 0; c < 4; c++) begin
        if (got[c] !== want[c]) begin
          if (errs[k][c] == 0) begin
            badGot[k][c] = got[c];
            badWant[k][c] = want[c];
          end
          errs[k][c]++;
        end
      end
    end
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++) begin
        testsRun++;
        if (errs[d][c] != 0) begin
          testsFailed++;
          $display("[TB] FAIL frame%0d digit%0d %s: %0d bad cycles, first got %h expected %h",
                   rec.id, d, catName[c], errs[d][c], badGot[d][c], badWant[d][c]);
        end
      end
    testsRun++;
    if (fdErr != 0) begin
      testsFailed++;
      $display("[TB] FAIL frame%0d frame_done period: %0d bad cycles, expected one pulse every 64",
               rec.id, fdErr);
    end
  endtask

  initial begin : monitor
    frameExp_t rec;
    forever begin
      @(negedge clock);
      while (frame_done && expQ.size() > 0) begin
        monitorBusy = 1'b1;
        rec = expQ.pop_front();
        checkOutput(rec);
        monitorBusy = 1'b0;
      end
    end
  end

  initial begin : stimulus
    bit idle;
    repeat (3) @(negedge clock);
    check("reset anode", {12'b0, anode}, 16'h000F);
    check("reset cathode", {9'b0, cathode}, 16'h007F);
    check("reset dp_n", {15'b0, dp_n}, 16'h0001);
    check("reset frame_done", {15'b0, frame_done}, 16'h0000);
    check("reset scan_index", {14'b0, scan_index}, 16'h0000);
    reset = 1'b0;

    // No load yet: the first checked frame stays dark.
    expQ.push_back(mkExp(8'd1, '0, {4{7'h7F}}, 4'b0000));

    // Two mid-frame loads; the second wins and appears next frame only.
    waitFrame("frame1");
    repeat (10) @(negedge clock);
    applyStimulus(16'hAAAA, 4'hF, 4'hF, 2'd3);
    repeat (4) @(negedge clock);
    applyStimulus(16'hF018, 4'b0010, 4'hF, 2'd3);
    expQ.push_back(mkExp(8'd2, {4{5'd12}}, {7'h38, 7'h01, 7'h4F, 7'h00}, 4'b0010));

    waitFrame("frame2");
    repeat (20) @(negedge clock);
    applyStimulus(16'hC5A3, 4'b1111, 4'b0101, 2'd1);
    expQ.push_back(mkExp(8'd3, {5'd0, 5'd4, 5'd0, 5'd4}, {7'h31, 7'h24, 7'h08, 7'h06}, 4'b0101));

    waitFrame("frame3");
    repeat (30) @(negedge clock);
    applyStimulus(16'h1234, 4'hF, 4'hF, 2'd0);
    expQ.push_back(mkExp(8'd4, '0, {4{7'h7F}}, 4'b0000));

    // Load exactly on the boundary cycle (slot 15 of digit 3).
    waitFrame("frame4");
    repeat (63) @(negedge clock);
    expQ.push_back(mkExp(8'd5, {4{5'd8}}, {7'h30, 7'h04, 7'h12, 7'h0F}, 4'b1001));
    applyStimulus(16'hE927, 4'b1001, 4'hF, 2'd2);

    // Mid-slot reset with pending shadow data that must be discarded.
    waitFrame("frame6");
    applyStimulus(16'h8888, 4'hF, 4'hF, 2'd3);
    repeat (2) @(negedge clock);
    check("lit before reset anode", {12'b0, anode}, 16'h000E);
    #2 reset = 1'b1;
    #1;
    check("async reset anode", {12'b0, anode}, 16'h000F);
    check("async reset cathode", {9'b0, cathode}, 16'h007F);
    check("async reset dp_n", {15'b0, dp_n}, 16'h0001);
    check("async reset scan_index", {14'b0, scan_index}, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    expQ.push_back(mkExp(8'd7, '0, {4{7'h7F}}, 4'b0000));

    waitFrame("post-reset frame1");
    waitFrame("post-reset frame2");
    idle = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!monitorBusy && expQ.size() == 0) begin
        idle = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!idle) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard drain: %0d frames still pending, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
